regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port (WE/RW/D_IN) of the 2-read/1-write register file between NREQ independent requesters.
- Round-robin arbitration with valid/ready handshake per requester.
- Optional locked bursts: a requester keeps the port for up to MAX_BURST consecutive writes.
- Registered outputs drive the register file directly; read ports are untouched.

Parameters:
M, 8, number of registers in the target register file (AW = $clog2(M))
N, 8, data width in bits
NREQ, 4, number of write requesters (>=1; IW = max(1,$clog2(NREQ)))
MAX_BURST, 4, max consecutive writes under lock (>=1; 1 disables locking)

Ports:
clk  input  1  clock; all state on posedge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  requester i has a write pending
req_lock  input  NREQ  requester i asks to keep the grant after this write
req_addr  input  NREQ*AW  packed; slice i = [i*AW +: AW]
req_data  input  NREQ*N  packed; slice i = [i*N +: N]
req_ready  output  NREQ  combinational; one-hot or zero; transfer when valid&ready
we  output  1  register-file write enable (registered)
rw  output  AW  register-file write address (registered)
d_in  output  N  register-file write data (registered)
grant_id  output  IW  requester whose write is currently on we (registered)
busy  output  1  1 while in LOCKED state

Behaviour:
- Reset (rst=1 at posedge): we=0, rw=0, d_in=0, grant_id=0, busy=0, rr pointer ptr=0, state=ARB, burst count=0. req_ready forced to 0 while rst=1.
- Handshake: a transfer for requester i occurs in a cycle with req_valid[i]&req_ready[i]. While valid and not ready, the requester holds addr/data/lock stable. At most one transfer per cycle.
- Latency: transfer in cycle T -> we=1, rw/d_in/grant_id = transferred values in cycle T+1. we is high exactly one cycle per transfer. Written data is readable on Q1/Q2 from cycle T+2.
- No transfer in a cycle -> we=0 next cycle. rw/d_in/grant_id hold their previous values.
- State ARB:
  - Winner w = first i with req_valid[i], searching ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready[w]=1; transfer occurs.
  - If req_lock[w]=1 and MAX_BURST>1: go to LOCKED, owner=w, count=1; ptr unchanged.
  - Otherwise stay in ARB with ptr <= (w+1) mod NREQ.
  - No valid requester: ready=0, nothing changes.
- State LOCKED: only owner may receive ready; all other requesters stall.
  - Owner valid: req_ready[owner]=1, transfer, count++.
  - Exit to ARB on that transfer when req_lock[owner]=0 or count+1==MAX_BURST. On exit, ptr <= (owner+1) mod NREQ and count=0.
  - Owner valid=0: no transfer; return to ARB next cycle; ptr <= (owner+1) mod NREQ. The lock is released.
- Fairness: after any grant ends, the granted requester has lowest priority. With all requesters continuously valid and unlocked, grants rotate 0,1,...,NREQ-1,0,...
- Same-address writes on consecutive transfers are applied in transfer order; last write wins.
- NREQ=1: ptr stays 0, grant_id=0. MAX_BURST=1: req_lock ignored, LOCKED never entered.
- rst mid-burst: abandons the lock; the pending output write is dropped (we=0 next cycle).

Optional Feature:
- Macro REGFILE_ARB_STATS_EN.
- Defined:
  - Adds output port contention_cnt (16 bits).
  - Increments by 1 each cycle in which >=2 bits of req_valid are set and a transfer occurs.
  - Saturates at 16'hFFFF; reset to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package regfile_arb_pkg: enum arb_state_e {ARB, LOCKED}, width helper functions for AW/IW, counter width constant CNT_W=16.
- One combinational sub-module regfile_rr_pick.
  - Inputs: req vector, ptr.
  - Outputs: winner index and a found flag.
  - Behaviour: rotating priority search.
- The FSM, output registers and the optional counter live in the top.

Test Plan:
- Reset and idle: rst=1 for 2 cycles with all req_valid=4'b1111 -> req_ready=0, we=0, rw=0, d_in=0, grant_id=0. Release rst, all idle -> we stays 0.
- Single write: req0 addr=3 data=8'hA5 for one cycle -> req_ready=4'b0001 that cycle. Next cycle we=1, rw=3, d_in=8'hA5, grant_id=0. Reading R1=3 two cycles after transfer gives Q1=8'hA5.
- Round-robin: req_valid=4'b1111 held, lock=0 -> grant_id sequence 0,1,2,3,0 on five consecutive we pulses.
- Locked burst: req2 lock=1 valid for 6 cycles with MAX_BURST=4, req0 valid throughout -> four consecutive grants to 2 (busy=1), then req0 granted. ptr resumes at 3.
- Lock drop: req1 locked and granted once, then req_valid[1]=0 -> next cycle busy=0 and the next valid requester above 1 is granted. A reset during LOCKED returns to ARB with ptr=0.
- Stats (REGFILE_ARB_STATS_EN): 10 cycles with req_valid=4'b0011 -> contention_cnt=10. Saturation check: preload to 16'hFFFE, 3 contended cycles -> 16'hFFFF.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and width helpers for the register-file write-port arbiter.
package regfile_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int CNT_W = 16;

  function automatic int aw_of(int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int iw_of(int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side handshake bundle plus the register-file write port it drives.
interface regfile_wr_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int M    = 8,
  parameter int N    = 8,
  parameter int NREQ = 4
);
  localparam int AW = aw_of(M);
  localparam int IW = iw_of(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*N-1:0]  req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we;
  logic [AW-1:0]      rw;
  logic [N-1:0]       d_in;
  logic [IW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, we, rw, d_in, grant_id, busy
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, we, rw, d_in, grant_id, busy
  );

endinterface

// File: rtl/regfile_rr_pick.sv
// Rotating-priority search: first set request at or after ptr, wrapping.
module regfile_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   winner_o,
  output logic            found_o
);

  // Scan from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NREQ]) begin
        winner_o = IW'((int'(ptr_i) + k) % NREQ);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port, with optional locked bursts.
// Define REGFILE_ARB_STATS_EN to add the saturating contention_cnt output.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int M         = 8,
  parameter int N         = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input logic clk,
  input logic rst,
  regfile_wr_arbiter_if.slave bus
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] contention_cnt
`endif
);

  localparam int AW = aw_of(M);
  localparam int IW = iw_of(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  arb_state_e      state_q;
  logic [IW-1:0]   ptr_q, owner_q, grant_q;
  logic [BW-1:0]   cnt_q;
  logic            we_q;
  logic [AW-1:0]   rw_q;
  logic [N-1:0]    d_in_q;

  logic [IW-1:0]   winner, xfer_id;
  logic            found, xfer;
  logic [NREQ-1:0] ready;

  regfile_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .winner_o(winner),
    .found_o (found)
  );

  function automatic logic [IW-1:0] next_idx(logic [IW-1:0] i);
    return (i == LAST) ? '0 : IW'(i + 1'b1);
  endfunction

  always_comb begin
    ready   = '0;
    xfer_id = winner;
    if (!rst) begin
      if (state_q == LOCKED) begin
        xfer_id        = owner_q;
        ready[owner_q] = bus.req_valid[owner_q];
      end else if (found) begin
        ready[winner] = 1'b1;
      end
    end
    xfer = |(ready & bus.req_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      we_q    <= 1'b0;
      rw_q    <= '0;
      d_in_q  <= '0;
    end else begin
      we_q <= xfer;
      if (xfer) begin
        rw_q    <= bus.req_addr[int'(xfer_id)*AW +: AW];
        d_in_q  <= bus.req_data[int'(xfer_id)*N +: N];
        grant_q <= xfer_id;
      end
      case (state_q)
        ARB: begin
          if (found) begin
            if (bus.req_lock[winner] && (MAX_BURST > 1)) begin
              state_q <= LOCKED;
              owner_q <= winner;
              cnt_q   <= BW'(1);
            end else begin
              ptr_q <= next_idx(winner);
            end
          end
        end
        LOCKED: begin
          // Owner dropping valid releases the lock just like a burst end.
          if (!bus.req_valid[owner_q] || !bus.req_lock[owner_q] ||
              (int'(cnt_q) + 1 == MAX_BURST)) begin
            state_q <= ARB;
            ptr_q   <= next_idx(owner_q);
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + BW'(1);
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.we        = we_q;
  assign bus.rw        = rw_q;
  assign bus.d_in      = d_in_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == LOCKED);

`ifdef REGFILE_ARB_STATS_EN
  logic [CNT_W-1:0] cont_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cont_q <= '0;
    end else if (xfer && ($countones(bus.req_valid) >= 2) && (cont_q != '1)) begin
      cont_q <= cont_q + CNT_W'(1);
    end
  end

  assign contention_cnt = cont_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: reference arbitration model, grant-order and readback checks.
module tb_regfile_wr_arbiter;
  import regfile_arb_pkg::*;

  localparam int M = 8, N = 8, NREQ = 4, MAX_BURST = 4;
  localparam int AW = 3, IW = 2;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [N-1:0]  d;
    logic [IW-1:0] id;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  regfile_wr_arbiter_if #(.M(M), .N(N), .NREQ(NREQ)) bus ();
`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] contention_cnt;
`endif

  regfile_wr_arbiter #(.M(M), .N(N), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef REGFILE_ARB_STATS_EN
    ,
    .contention_cnt(contention_cnt)
`endif
  );

  always #5 clk = ~clk;

  sb_t             sbq[$];
  int              glog[$];
  logic [N-1:0]    rf[M];
  bit              m_locked = 1'b0;
  int              m_ptr = 0, m_owner = 0, m_cnt = 0, m_cont = 0;
  bit              exp_we = 1'b0;
  logic [NREQ-1:0] last_rdy = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // register file behind the write port, for readback checks
  always @(posedge clk) if (bus.we) rf[bus.rw] <= bus.d_in;

  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int   w;
    sb_t  e;
    er = '0;
    w  = -1;
    if (!rst) begin
      if (m_locked) begin
        if (bus.req_valid[m_owner]) w = m_owner;
      end else begin
        for (int off = 0; off < NREQ; off++) begin
          if (w < 0 && bus.req_valid[(m_ptr + off) % NREQ]) w = (m_ptr + off) % NREQ;
        end
      end
      if (w >= 0) er[w] = 1'b1;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    chk("we", 32'(bus.we), 32'(exp_we));
    chk("busy", 32'(bus.busy), 32'(m_locked));
`ifdef REGFILE_ARB_STATS_EN
    chk("contention_cnt", 32'(contention_cnt), 32'(m_cont));
`endif
    if (bus.we) begin
      glog.push_back(int'(bus.grant_id));
      if (sbq.size() == 0) begin
        chk("sb_depth", 32'(sbq.size()), 32'd1);
      end else begin
        e = sbq.pop_front();
        chk("rw", 32'(bus.rw), 32'(e.a));
        chk("d_in", 32'(bus.d_in), 32'(e.d));
        chk("grant_id", 32'(bus.grant_id), 32'(e.id));
      end
    end
    last_rdy = er;
    if (rst) begin
      m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_cont = 0;
      exp_we = 1'b0;
    end else begin
      exp_we = (w >= 0);
      if (w >= 0) begin
        sbq.push_back('{a: bus.req_addr[w*AW +: AW], d: bus.req_data[w*N +: N], id: IW'(w)});
        if ($countones(bus.req_valid) >= 2 && m_cont < 65535) m_cont++;
      end
      if (m_locked) begin
        if (w >= 0) begin
          m_cnt++;
          if (!bus.req_lock[w] || m_cnt == MAX_BURST) begin
            m_locked = 1'b0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0;
          end
        end else begin
          m_locked = 1'b0; m_ptr = (m_owner + 1) % NREQ; m_cnt = 0;
        end
      end else if (w >= 0) begin
        if (bus.req_lock[w] && MAX_BURST > 1) begin
          m_locked = 1'b1; m_owner = w; m_cnt = 1;
        end else begin
          m_ptr = (w + 1) % NREQ;
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [NREQ-1:0] v, logic [NREQ-1:0] l);
    bus.req_valid = v;
    bus.req_lock  = l;
  endtask

  task automatic set_req(int i, logic [AW-1:0] a, logic [N-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*N +: N]   = d;
  endtask

  task automatic chk_log(string tag, int exp[]);
    chk({tag, "_len"}, 32'(glog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < glog.size(); i++) chk(tag, 32'(glog[i]), 32'(exp[i]));
    glog.delete();
  endtask

  initial begin
    rst = 1'b1;
    drive(4'b1111, 4'b0000);
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 4), N'(8'h10 + i));
    tick(2);
    @(negedge clk);
    chk("rst_rw", 32'(bus.rw), 0);
    chk("rst_d_in", 32'(bus.d_in), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    tick();
    rst = 1'b0;
    drive(4'b0000, 4'b0000);
    tick(3);

    // single write and readback
    set_req(0, 3'd3, 8'hA5);
    drive(4'b0001, 4'b0000);
    tick();
    drive(4'b0000, 4'b0000);
    tick(2);
    @(negedge clk);
    chk("rf_readback", 32'(rf[3]), 32'h A5);
    tick();

    // round robin from ptr=0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), N'(8'h30 + i));
    drive(4'b1111, 4'b0000);
    tick(5);
    drive(4'b0000, 4'b0000);
    tick(2);
    chk_log("rr_order", '{0, 1, 2, 3, 0});

    // locked burst by req2 against req0, ptr=1
    drive(4'b0101, 4'b0100);
    tick(6);
    drive(4'b0000, 4'b0000);
    tick(2);
    chk_log("burst_order", '{2, 2, 2, 2, 0, 2});

    // lock released by owner dropping valid, then reset while locked
    drive(4'b0010, 4'b0010);
    tick();
    drive(4'b1001, 4'b0000);
    @(negedge clk);
    chk("drop_busy_hold", 32'(bus.busy), 1);
    tick();
    @(negedge clk);
    chk("drop_busy_clear", 32'(bus.busy), 0);
    chk("drop_ready", 32'(bus.req_ready), 32'b1000);
    tick();
    set_req(0, 3'd5, 8'h11);
    set_req(1, 3'd5, 8'h22);
    drive(4'b0010, 4'b0010);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'b0011, 4'b0000);
    tick(3);
    drive(4'b0000, 4'b0000);
    tick(2);
    chk_log("drop_order", '{1, 3, 1, 0, 1, 0});
    @(negedge clk);
    chk("same_addr_last_wins", 32'(rf[5]), 32'h11);
    tick();

    // random traffic; held requests keep addr/data/lock stable
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!(bus.req_valid[i] && !last_rdy[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_lock[i]  = ($urandom_range(0, 2) == 0);
          set_req(i, AW'($urandom), N'($urandom));
        end
      end
      tick();
    end
    rst = 1'b0;
    drive(4'b0000, 4'b0000);
    tick(3);

`ifdef REGFILE_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'b0011, 4'b0000);
    tick(10);
    drive(4'b0000, 4'b0000);
    @(negedge clk);
    chk("contention_10", 32'(contention_cnt), 32'd10);
    tick(2);
`endif

    chk("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
